// File: rtl/flac_frame_header_parser.sv
// flac_frame_header_parser: walks one FLAC frame header byte by byte from
// 16-bit word RAM, validates it (sync, codes, UTF-8, CRC-8) and latches fields.
module flac_frame_header_parser #(
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_CHANNELS = 8
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic                  iEnable,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddr,
    input  logic [15:0]           iData,
    output logic [ADDR_WIDTH-1:0] oReadAddr,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError,
    output logic [3:0]            oErrCode,
    output logic                  oVarBlock,
    output logic [16:0]           oBlockSize,
    output logic [19:0]           oSampleRateHz,
    output logic [3:0]            oChanAssign,
    output logic [3:0]            oNumChannels,
    output logic [2:0]            oBpsCode,
    output logic [35:0]           oFrameNumber,
    output logic [ADDR_WIDTH-1:0] oNextAddr,
    output logic                  oNextOdd
);

    typedef enum logic [3:0] {
        IDLE, SYNC0, SYNC1, CODES0, CODES1, UTF8_FIRST,
        UTF8_CONT, BS_EXT, SR_EXT, CRC, DONE
    } state_t;

    state_t                state;
    logic                  ph;
    logic [4:0]            b;
    logic [ADDR_WIDTH-1:0] base;
    logic [7:0]            crc;
    logic [3:0]            err;
    logic [3:0]            bs_code;
    logic [3:0]            sr_code;
    logic [2:0]            utf_rem;
    logic                  ext_idx;
    logic [7:0]            ext_hi;

    logic [7:0]            cur;
    logic [7:0]            crc_nx;
    logic [16:0]           bs_dec;
    logic [19:0]           sr_dec;
    logic [3:0]            lead;
    logic [4:0]            chan_cnt;
    logic [7:0]            utf_val;
    logic [15:0]           ext_val;
    logic [19:0]           sr_ext_val;
    logic [4:0]            b_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [3:0]            bad_code;
    logic                  sr_ext;
    logic                  bs_last;
    logic                  sr_last;
    state_t                after_utf;
    state_t                after_bs;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Current byte selection and field decoding of that byte
    always_comb begin
        cur     = b[0] ? iData[7:0] : iData[15:8];
        crc_nx  = crc8(crc, cur);
        b_nx    = b + 5'd1;
        addr_nx = base + ADDR_WIDTH'(b_nx[4:1]);

        bs_dec = 17'd0;
        case (cur[7:4])
            4'd1: bs_dec = 17'd192;
            4'd2, 4'd3, 4'd4, 4'd5:
                bs_dec = 17'd576 << 4'(cur[7:4] - 4'd2);
            default:
                if (cur[7]) bs_dec = 17'd256 << cur[6:4];
        endcase

        sr_dec = 20'd0;
        case (cur[3:0])
            4'd1:  sr_dec = 20'd88200;
            4'd2:  sr_dec = 20'd176400;
            4'd3:  sr_dec = 20'd192000;
            4'd4:  sr_dec = 20'd8000;
            4'd5:  sr_dec = 20'd16000;
            4'd6:  sr_dec = 20'd22050;
            4'd7:  sr_dec = 20'd24000;
            4'd8:  sr_dec = 20'd32000;
            4'd9:  sr_dec = 20'd44100;
            4'd10: sr_dec = 20'd48000;
            4'd11: sr_dec = 20'd96000;
            default: sr_dec = 20'd0;
        endcase

        casez (cur)
            8'b0???????: lead = 4'd0;
            8'b10??????: lead = 4'd1;
            8'b110?????: lead = 4'd2;
            8'b1110????: lead = 4'd3;
            8'b11110???: lead = 4'd4;
            8'b111110??: lead = 4'd5;
            8'b1111110?: lead = 4'd6;
            8'b11111110: lead = 4'd7;
            default:     lead = 4'd8;
        endcase

        chan_cnt = cur[7] ? 5'd2 : {1'b0, cur[7:4]} + 5'd1;
        utf_val  = cur & (8'hFF >> (lead + 4'd1));
        ext_val  = ext_idx ? {ext_hi, cur} : {8'd0, cur};

        case (sr_code)
            4'd12:   sr_ext_val = 20'(ext_val[7:0]) * 20'd1000;
            4'd14:   sr_ext_val = 20'(ext_val) * 20'd10;
            default: sr_ext_val = 20'(ext_val);
        endcase

        sr_ext  = (sr_code[3:2] == 2'b11) && (sr_code != 4'd15);
        bs_last = (bs_code == 4'd6) || ext_idx;
        sr_last = (sr_code == 4'd12) || ext_idx;

        after_bs  = sr_ext ? SR_EXT : CRC;
        after_utf = (bs_code[3:1] == 3'b011) ? BS_EXT : after_bs;
    end

    // Validity check of the byte being processed in the current state
    always_comb begin
        bad_code = 4'd0;
        case (state)
            SYNC0:
                if (cur != 8'hFF) bad_code = 4'd1;
            SYNC1:
                if (cur[7:1] != 7'h7C) bad_code = 4'd1;
            CODES0:
                if (cur[7:4] == 4'd0) bad_code = 4'd3;
                else if (cur[3:0] == 4'd15) bad_code = 4'd4;
            CODES1:
                if (cur[7:4] > 4'd10 || int'(chan_cnt) > MAX_CHANNELS)
                    bad_code = 4'd5;
                else if (cur[2:1] == 2'b11) bad_code = 4'd6;
                else if (cur[0]) bad_code = 4'd2;
            UTF8_FIRST:
                if (lead == 4'd1 || lead == 4'd8 ||
                    (lead == 4'd7 && !oVarBlock))
                    bad_code = 4'd7;
            UTF8_CONT:
                if (cur[7:6] != 2'b10) bad_code = 4'd7;
            CRC:
                if (cur != crc) bad_code = 4'd8;
            default: bad_code = 4'd0;
        endcase
    end

    // Parser FSM: two enabled cycles per byte, abort to DONE on first error
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state         <= IDLE;
            ph            <= 1'b0;
            b             <= '0;
            base          <= '0;
            crc           <= '0;
            err           <= '0;
            bs_code       <= '0;
            sr_code       <= '0;
            utf_rem       <= '0;
            ext_idx       <= 1'b0;
            ext_hi        <= '0;
            oReadAddr     <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oError        <= 1'b0;
            oErrCode      <= '0;
            oVarBlock     <= 1'b0;
            oBlockSize    <= '0;
            oSampleRateHz <= '0;
            oChanAssign   <= '0;
            oNumChannels  <= '0;
            oBpsCode      <= '0;
            oFrameNumber  <= '0;
            oNextAddr     <= '0;
            oNextOdd      <= 1'b0;
        end else if (iEnable) begin
            oDone <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    state     <= SYNC0;
                    ph        <= 1'b0;
                    b         <= '0;
                    base      <= iBaseAddr;
                    oReadAddr <= iBaseAddr;
                    crc       <= '0;
                    err       <= '0;
                    ext_idx   <= 1'b0;
                    oBusy     <= 1'b1;
                end
                DONE: begin
                    oDone    <= 1'b1;
                    oBusy    <= 1'b0;
                    oError   <= (err != 4'd0);
                    oErrCode <= err;
                    state    <= IDLE;
                end
                default: if (!ph) begin
                    ph <= 1'b1;
                end else if (bad_code != 4'd0) begin
                    ph    <= 1'b0;
                    err   <= bad_code;
                    state <= DONE;
                end else begin
                    ph        <= 1'b0;
                    b         <= b_nx;
                    crc       <= crc_nx;
                    oReadAddr <= addr_nx;
                    case (state)
                        SYNC0: state <= SYNC1;
                        SYNC1: begin
                            oVarBlock <= cur[0];
                            state     <= CODES0;
                        end
                        CODES0: begin
                            bs_code       <= cur[7:4];
                            sr_code       <= cur[3:0];
                            oBlockSize    <= bs_dec;
                            oSampleRateHz <= sr_dec;
                            state         <= CODES1;
                        end
                        CODES1: begin
                            oChanAssign  <= cur[7:4];
                            oNumChannels <= chan_cnt[3:0];
                            oBpsCode     <= cur[3:1];
                            state        <= UTF8_FIRST;
                        end
                        UTF8_FIRST: begin
                            oFrameNumber <= 36'(utf_val);
                            utf_rem      <= 3'(lead - 4'd1);
                            state <= (lead == 4'd0) ? after_utf : UTF8_CONT;
                        end
                        UTF8_CONT: begin
                            oFrameNumber <= {oFrameNumber[29:0], cur[5:0]};
                            utf_rem      <= utf_rem - 3'd1;
                            if (utf_rem == 3'd1) state <= after_utf;
                        end
                        BS_EXT: if (bs_last) begin
                            oBlockSize <= 17'(ext_val) + 17'd1;
                            ext_idx    <= 1'b0;
                            state      <= after_bs;
                        end else begin
                            ext_hi  <= cur;
                            ext_idx <= 1'b1;
                        end
                        SR_EXT: if (sr_last) begin
                            oSampleRateHz <= sr_ext_val;
                            ext_idx       <= 1'b0;
                            state         <= CRC;
                        end else begin
                            ext_hi  <= cur;
                            ext_idx <= 1'b1;
                        end
                        CRC: begin
                            oNextAddr <= addr_nx;
                            oNextOdd  <= b_nx[0];
                            state     <= DONE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flac_frame_header_parser.sv
// tb_flac_frame_header_parser: scoreboard bench, one task per scenario,
// enabled-cycle RAM model, DUT built with MAX_CHANNELS = 2.
module tb_flac_frame_header_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] rdata;
    logic [15:0] raddr;
    logic        busy, done, error, var_block, next_odd;
    logic [3:0]  err_code, chan_assign, num_ch;
    logic [16:0] block_size;
    logic [19:0] rate;
    logic [2:0]  bps;
    logic [35:0] frame_no;
    logic [15:0] next_addr;

    always #5 clk = ~clk;

    flac_frame_header_parser #(.ADDR_WIDTH(16), .MAX_CHANNELS(2)) dut (
        .iClock(clk), .iReset_n(rst_n), .iEnable(en), .iStart(start),
        .iBaseAddr(base_addr), .iData(rdata), .oReadAddr(raddr),
        .oBusy(busy), .oDone(done), .oError(error), .oErrCode(err_code),
        .oVarBlock(var_block), .oBlockSize(block_size),
        .oSampleRateHz(rate), .oChanAssign(chan_assign),
        .oNumChannels(num_ch), .oBpsCode(bps), .oFrameNumber(frame_no),
        .oNextAddr(next_addr), .oNextOdd(next_odd)
    );

    logic [15:0] mem [0:255];

    always @(posedge clk) if (en) rdata <= mem[raddr[7:0]];

    typedef struct packed {
        logic        err;
        logic [3:0]  code;
        logic        vb;
        logic [16:0] blk;
        logic [19:0] rate;
        logic [3:0]  ca;
        logic [3:0]  nch;
        logic [2:0]  bps;
        logic [35:0] fn;
        logic [15:0] na;
        logic        odd;
        logic [7:0]  cyc;
    } res_t;

    res_t       expq[$];
    logic [7:0] hb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
            else      r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    function automatic res_t good(input logic vb, input int blk, input int sr,
                                  input int ca, input int nch, input int bp,
                                  input logic [35:0] fn, input int na,
                                  input int odd, input int cyc);
        res_t r;
        r      = '0;
        r.vb   = vb;
        r.blk  = blk[16:0];
        r.rate = sr[19:0];
        r.ca   = ca[3:0];
        r.nch  = nch[3:0];
        r.bps  = bp[2:0];
        r.fn   = fn;
        r.na   = na[15:0];
        r.odd  = odd[0];
        r.cyc  = cyc[7:0];
        return r;
    endfunction

    function automatic res_t bad(input int code, input int cyc);
        res_t r;
        r      = '0;
        r.err  = 1'b1;
        r.code = code[3:0];
        r.cyc  = cyc[7:0];
        return r;
    endfunction

    function automatic res_t snap();
        res_t r;
        r.err  = error;
        r.code = err_code;
        r.vb   = var_block;
        r.blk  = block_size;
        r.rate = rate;
        r.ca   = chan_assign;
        r.nch  = num_ch;
        r.bps  = bps;
        r.fn   = frame_no;
        r.na   = next_addr;
        r.odd  = next_odd;
        r.cyc  = 8'd0;
        return r;
    endfunction

    task automatic wr(input int base, input int i, input logic [7:0] v);
        if (i % 2 == 0) mem[base + i / 2][15:8] = v;
        else            mem[base + i / 2][7:0]  = v;
    endtask

    // write the byte queue at a word base, optionally followed by its CRC
    task automatic put(input int base, input bit add_crc, input logic [7:0] flip);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < hb.size(); i++) begin
            c = crc_step(c, hb[i]);
            wr(base, i, hb[i]);
        end
        if (add_crc) wr(base, hb.size(), c ^ flip);
    endtask

    task automatic load_basic(input logic [15:0] last);
        mem[16'h10] = 16'hFFF8;
        mem[16'h11] = 16'hC918;
        mem[16'h12] = last;
    endtask

    // start a parse and wait (bounded) for oDone; poke re-asserts iStart mid-parse
    task automatic run_parse(input int base, input int poke, output res_t obs);
        bit got;
        @(negedge clk);
        base_addr = base[15:0];
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        obs     = '0;
        obs.cyc = 8'hFF;
        got     = 1'b0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(posedge clk);
            #1;
            if (n == poke) begin
                start     = 1'b1;
                base_addr = 16'h0040;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                obs     = snap();
                obs.cyc = n[7:0];
                got     = 1'b1;
            end
        end
        start = 1'b0;
        if (!got) $display("FAIL timeout waiting for done base=%0h", base);
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, error, err_code, var_block, block_size, rate,
             chan_assign, num_ch, bps, frame_no, next_addr, next_odd,
             raddr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b addr=%h blk=%h want all 0",
                     busy, done, raddr, block_size);
        end
    endtask

    task automatic test_basic();
        res_t o, e;
        load_basic(16'h00C2);
        expq.push_back(good(0, 4096, 44100, 1, 2, 4, 36'd0, 16'h13, 0, 13));
        run_parse(16'h10, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL basic got=%h want=%h", o, e);
        end
    endtask

    task automatic test_crc_err();
        res_t o, e;
        load_basic(16'h00C3);
        expq.push_back(bad(8, 13));
        run_parse(16'h10, 0, o);
        e = expq.pop_front();
        checks++;
        if ({o.err, o.code, o.cyc} !== {e.err, e.code, e.cyc}) begin
            errors++;
            $display("FAIL crc_err got err=%b code=%0d cyc=%0d want 1 8 13",
                     o.err, o.code, o.cyc);
        end
    endtask

    task automatic test_sync_err();
        res_t o, e;
        mem[16'h10] = 16'hFFF0;
        expq.push_back(bad(1, 5));
        run_parse(16'h10, 0, o);
        e = expq.pop_front();
        checks++;
        if ({o.err, o.code, o.cyc} !== {e.err, e.code, e.cyc}) begin
            errors++;
            $display("FAIL sync_err got err=%b code=%0d cyc=%0d want 1 1 5",
                     o.err, o.code, o.cyc);
        end
        checks++;
        if (raddr !== 16'h0010) begin
            errors++;
            $display("FAIL sync_no_read addr=%h want 0010", raddr);
        end
    endtask

    task automatic test_ext();
        res_t o, e;
        hb = '{8'hFF, 8'hF9, 8'h7D, 8'h18, 8'hE2, 8'h82, 8'hAC,
               8'h0F, 8'hFF, 8'h56, 8'h22};
        put(16'h20, 1'b1, 8'h00);
        expq.push_back(good(1, 4096, 22050, 1, 2, 4, 36'h20AC, 16'h26, 0, 25));
        run_parse(16'h20, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ext16 got=%h want=%h", o, e);
        end
        hb = '{8'hFF, 8'hF8, 8'h6C, 8'h08, 8'hC2, 8'h80, 8'h3F, 8'h30};
        put(16'h30, 1'b1, 8'h00);
        expq.push_back(good(0, 64, 48000, 0, 1, 4, 36'h80, 16'h34, 1, 19));
        run_parse(16'h30, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ext8_odd got=%h want=%h", o, e);
        end
        hb = '{8'hFF, 8'hF9, 8'hC9, 8'h18, 8'hFE, 8'h83, 8'hBF,
               8'hBF, 8'hBF, 8'hBF, 8'hBF};
        put(16'h50, 1'b1, 8'h00);
        expq.push_back(good(1, 4096, 44100, 1, 2, 4, 36'h0FFFFFFFF, 16'h56, 0, 25));
        run_parse(16'h50, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL utf8_7byte got=%h want=%h", o, e);
        end
    endtask

    task automatic test_codes();
        logic [7:0]  cb [7];
        logic [15:0] ex [7];
        int          ne [7];
        int          eb [7];
        int          er [7];
        res_t        o, e;
        int          nb;
        cb = '{8'h11, 8'h5B, 8'h80, 8'h2E, 8'hF4, 8'h76, 8'h9C};
        ex = '{16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'hFFFF, 16'h0030};
        ne = '{0, 0, 0, 2, 0, 2, 1};
        eb = '{192, 4608, 256, 576, 32768, 65536, 512};
        er = '{88200, 96000, 0, 46600, 8000, 22050, 48000};
        for (int i = 0; i < 7; i++) begin
            hb = '{8'hFF, 8'hF8, cb[i], 8'h18, 8'h00};
            if (ne[i] == 2) hb.push_back(ex[i][15:8]);
            if (ne[i] >= 1) hb.push_back(ex[i][7:0]);
            put(16'h60, 1'b1, 8'h00);
            nb = 6 + ne[i];
            expq.push_back(good(0, eb[i], er[i], 1, 2, 4, 36'd0,
                                16'h60 + nb / 2, nb % 2, 2 * nb + 1));
            run_parse(16'h60, 0, o);
            e = expq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL codes_%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_errors();
        logic [47:0] eh [12];
        int          el [12];
        int          ec [12];
        int          ey [12];
        logic [47:0] h;
        res_t        o, e;
        eh = '{48'hFFF809000000, 48'hFFF8CF000000, 48'hFFF8C9580000,
               48'hFFF8C9B80000, 48'hFFF8C9160000, 48'hFFF8C9190000,
               48'hFFF8C918FF00, 48'hFFF8C9188000, 48'hFFF8C918FE00,
               48'hFFF8C918E2C0, 48'hFEF800000000, 48'hFFFA00000000};
        el = '{3, 3, 4, 4, 4, 4, 5, 5, 5, 6, 2, 2};
        ec = '{3, 4, 5, 5, 6, 2, 7, 7, 7, 7, 1, 1};
        ey = '{7, 7, 9, 9, 9, 9, 11, 11, 11, 13, 3, 5};
        for (int i = 0; i < 12; i++) begin
            h  = eh[i];
            hb = {};
            for (int k = 0; k < el[i]; k++) hb.push_back(h[47 - 8 * k -: 8]);
            put(16'h70, 1'b0, 8'h00);
            expq.push_back(bad(ec[i], ey[i]));
            run_parse(16'h70, 0, o);
            e = expq.pop_front();
            checks++;
            if ({o.err, o.code, o.cyc} !== {e.err, e.code, e.cyc}) begin
                errors++;
                $display("FAIL err_%0d got err=%b code=%0d cyc=%0d want 1 %0d %0d",
                         i, o.err, o.code, o.cyc, e.code, e.cyc);
            end
        end
    endtask

    task automatic test_enable();
        res_t o, e;
        bit   got;
        load_basic(16'h00C2);
        expq.push_back(good(0, 4096, 44100, 1, 2, 4, 36'd0, 16'h13, 0, 26));
        @(negedge clk);
        base_addr = 16'h10;
        start     = 1'b1;
        en        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        o     = '0;
        o.cyc = 8'hFF;
        got   = 1'b0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(negedge clk);
            en = ~en;
            @(posedge clk);
            #1;
            if (done) begin
                o     = snap();
                o.cyc = n[7:0];
                got   = 1'b1;
            end
        end
        @(negedge clk);
        en = 1'b1;
        e  = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL enable_toggle got=%h want=%h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        load_basic(16'h00C2);
        hb = '{8'hFF, 8'hF8, 8'h6C, 8'h08, 8'hC2, 8'h80, 8'h3F, 8'h30};
        put(16'h40, 1'b1, 8'h00);
        expq.push_back(good(0, 4096, 44100, 1, 2, 4, 36'd0, 16'h13, 0, 13));
        expq.push_back(good(0, 64, 48000, 0, 1, 4, 36'h80, 16'h44, 1, 19));
        run_parse(16'h10, 3, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL busy_start_ignored got=%h want=%h", o, e);
        end
        run_parse(16'h40, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL back_to_back got=%h want=%h", o, e);
        end
    endtask

    task automatic test_reset_mid();
        res_t o, e;
        load_basic(16'h00C2);
        @(negedge clk);
        base_addr = 16'h10;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, raddr, block_size} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b addr=%h blk=%h want 0",
                     busy, done, raddr, block_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expq.push_back(good(0, 4096, 44100, 1, 2, 4, 36'd0, 16'h13, 0, 13));
        run_parse(16'h10, 0, o);
        e = expq.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL after_reset got=%h want=%h", o, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n     = 1'b0;
        en        = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_crc_err();
        test_sync_err();
        test_ext();
        test_codes();
        test_errors();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flac_frame_header_parser.md
Name: flac_frame_header_parser

Overview:
- Parses one FLAC frame header from 16-bit big-endian word RAM, starting at a given word address.
- Checks the header CRC-8, decodes every header field, and reports where the first subframe starts.
- Sits in the frame decoder ahead of the per-channel subframe decoders.
- Generalises the earlier header stub:
  - parametrised address width and channel limit;
  - variable/fixed blocking strategy;
  - UTF-8 frame or sample numbers;
  - extended block-size and sample-rate bytes;
  - error reporting.

Parameters:
ADDR_WIDTH, 16, RAM word-address width
MAX_CHANNELS, 8, channel count above this is rejected (1..8)

Ports:
iClock  in  1  clock
iReset_n  in  1  asynchronous active-low reset
iEnable  in  1  clock enable; when low all state, including the byte-phase counter, holds
iStart  in  1  start parse; sampled only in IDLE
iBaseAddr  in  ADDR_WIDTH  word address of sync code (header always word-aligned)
iData  in  16  RAM read data, valid one enabled cycle after oReadAddr
oReadAddr  out  ADDR_WIDTH  RAM word address
oBusy  out  1  high from accepted iStart until oDone
oDone  out  1  one-cycle pulse at end of parse, good or bad
oError  out  1  valid with oDone; 1 = header rejected
oErrCode  out  4  1 sync, 2 reserved bit, 3 block-size code 0, 4 rate code 15, 5 channel code 11-15 or count > MAX_CHANNELS, 6 bps code 3/7, 7 bad UTF-8, 8 CRC mismatch
oVarBlock  out  1  blocking-strategy bit
oBlockSize  out  17  samples per channel
oSampleRateHz  out  20  0 = take from STREAMINFO
oChanAssign  out  4  raw channel-assignment code
oNumChannels  out  4  decoded channel count
oBpsCode  out  3  raw sample-size code
oFrameNumber  out  36  decoded UTF-8 value
oNextAddr  out  ADDR_WIDTH  word holding first subframe byte
oNextOdd  out  1  1 = first subframe byte is the low byte of that word

Behaviour:
- Reset: all outputs 0, state IDLE.
- Byte fetcher:
  - byte index b; address = base + (b>>1); byte = iData[15:8] if b even else iData[7:0].
  - Each header byte costs exactly 2 enabled cycles: address phase, then data/process phase.
- States: IDLE, SYNC0, SYNC1, CODES0, CODES1, UTF8_FIRST, UTF8_CONT, BS_EXT, SR_EXT, CRC, DONE.
- SYNC0/SYNC1:
  - First 15 bits must be 0x7FFC; otherwise error 1.
  - Last bit of byte 1 is oVarBlock.
- CODES0:
  - Block-size code [7:4]: 0 → error 3; 1 → 192; 2-5 → 576<<(n-2); 6 → 8-bit ext+1; 7 → 16-bit ext+1; 8-15 → 256<<(n-8).
  - Rate code [3:0]:
    - 0 → 0; 1 → 88200; 2 → 176400; 3 → 192000; 4 → 8000; 5 → 16000; 6 → 22050; 7 → 24000.
    - 8 → 32000; 9 → 44100; 10 → 48000; 11 → 96000.
    - 12 → 8-bit ext ×1000; 13 → 16-bit ext; 14 → 16-bit ext ×10; 15 → error 4.
- CODES1:
  - Channel code [7:4]: 0-7 → n+1 channels; 8-10 → 2 channels; 11-15 → error 5; count > MAX_CHANNELS → error 5.
  - Bps code [3:1]: 3 or 7 → error 6.
  - Bit 0 must be 0, else error 2.
- UTF-8:
  - Leading-ones count L of the first byte: 0 → 1 byte; 2-6 → L bytes; 7 (0xFE) → 7 bytes, allowed only when oVarBlock = 1.
  - L = 1, L = 8, or 0xFE with oVarBlock = 0 → error 7.
  - Each continuation byte must be 10xxxxxx, else error 7; value accumulates 6 bits per continuation byte.
- Extension bytes: BS_EXT (1 or 2 bytes) precedes SR_EXT (1 or 2 bytes); each state is skipped when not needed.
- CRC-8:
  - Polynomial 0x07, init 0x00, MSB-first, over every byte before the CRC byte.
  - CRC state compares the running CRC with the CRC byte; mismatch → error 8.
- Errors:
  - First error detected aborts immediately to DONE with that code; later checks are not performed.
  - Field outputs are then undefined and must be ignored.
- DONE:
  - oDone = 1 for one cycle, oBusy drops in the same cycle, return to IDLE.
  - Fields and oNextAddr/oNextOdd are registered and hold until the next accepted iStart.
- Latency: header of N bytes → oDone exactly 2N+1 enabled cycles after the iStart edge. Error after byte k → 2k+1.
- Corner cases:
  - iStart while busy is ignored.
  - Reset mid-parse returns immediately to IDLE with all outputs 0.
  - iEnable low mid-parse stretches latency with no loss of state.

Test Plan:
- Words FFF8, C918, 00C2 at base 0x0010 → oDone after 13 cycles, oError = 0, block 4096, rate 44100, 2 channels, bps code 4, frame 0, oNextAddr = 0x0013, oNextOdd = 0.
- Same header with last word 00C3 → oError = 1, oErrCode = 8 after 13 cycles.
- First word FFF0 → oErrCode = 1, oDone after 5 cycles, no further reads.
- Variable-block header with UTF-8 bytes E2 82 AC (value 0x20AC), block code 7 with ext 0x0FFF, rate code 13 with ext 0x5622, correct CRC → block 4096, rate 22050, oNextOdd per byte count.
- MAX_CHANNELS = 2 with channel code 5 → oErrCode = 5. Repeat with a UTF-8 continuation byte C0 → oErrCode = 7.
- Toggle iEnable every cycle during the first test → identical outputs at 26 cycles. Assert iReset_n low mid-parse → oBusy = 0 asynchronously, next iStart parses normally.
